// File: rtl/traffic_phase_sequencer.sv
// Two-road traffic phase sequencer: all-red, green, extension and yellow
// per road, with tick prescaler and demand-driven extension skip/cut.
module traffic_phase_sequencer #(
  parameter int TICK_DIV = 100000000,
  parameter int T_RED    = 2,
  parameter int T_GREEN  = 10,
  parameter int T_EXT    = 10,
  parameter int T_YELLOW = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req1,
  input  logic req2,
  output logic C2,
  output logic C1,
  output logic C0,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TM1 = (T_RED > T_GREEN) ? T_RED : T_GREEN;
  localparam int TM2 = (T_EXT > T_YELLOW) ? T_EXT : T_YELLOW;
  localparam int TM = (TM1 > TM2) ? TM1 : TM2;
  localparam int CW = (TM > 1) ? $clog2(TM) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    AR1 = 3'd0,
    G1  = 3'd1,
    E1  = 3'd2,
    Y1  = 3'd3,
    AR2 = 3'd4,
    G2  = 3'd5,
    E2  = 3'd6,
    Y2  = 3'd7
  } phase_e;

  phase_e          phase_q, phase_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            other;
  logic            is_green;
  logic            is_ext;
  logic            done;
  phase_e          step1;
  phase_e          step2;

  function automatic logic [CW-1:0] dwell(phase_e p);
    logic [CW-1:0] d;
    case (p[1:0])
      2'b00:   d = CW'(T_RED - 1);
      2'b01:   d = CW'(T_GREEN - 1);
      2'b10:   d = CW'(T_EXT - 1);
      default: d = CW'(T_YELLOW - 1);
    endcase
    return d;
  endfunction

  assign tick = en & rst_n & (pre_q == PRE_MAX);
  assign {C2, C1, C0} = phase_q;

  always_comb begin
    pre_d    = pre_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    // demand that matters is always from the road currently waiting
    other    = phase_q[2] ? req1 : req2;
    is_green = (phase_q[1:0] == 2'b01);
    is_ext   = (phase_q[1:0] == 2'b10);
    done     = (cnt_q == '0);
    step1    = phase_e'(phase_q + 3'd1);
    step2    = phase_e'(phase_q + 3'd2);
    if (en) begin
      pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + PW'(1);
    end
    if (tick) begin
      unique case (1'b1)
        is_green: begin
          if (done) phase_d = other ? step2 : step1;
        end
        is_ext: begin
          if (done || other) phase_d = step1;
        end
        default: begin
          if (done) phase_d = step1;
        end
      endcase
      cnt_d = (phase_d != phase_q) ? dwell(phase_d)
                                   : cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= AR1;
      pre_q   <= '0;
      cnt_q   <= CW'(T_RED - 1);
    end else begin
      phase_q <= phase_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Bench for traffic_phase_sequencer: tick-level reference model checked
// every cycle, plus directed timing checks with literal durations.
module tb_traffic_phase_sequencer;

  localparam int TD = 4;

  logic clk;
  logic rst_n;
  logic en;
  logic req1;
  logic req2;
  logic C2, C1, C0;
  logic tick;
  logic [2:0] code;

  int total = 0;
  int bad = 0;
  bit chk_on = 0;

  int dw_ticks [8] = '{2, 3, 4, 1, 2, 3, 4, 1};
  int durs [8] = '{8, 12, 16, 4, 8, 12, 16, 4};

  int m_ph = 0;
  int m_pre = 0;
  int m_left = 2;

  traffic_phase_sequencer #(
    .TICK_DIV(4),
    .T_RED(2),
    .T_GREEN(3),
    .T_EXT(4),
    .T_YELLOW(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .req1(req1),
    .req2(req2),
    .C2(C2),
    .C1(C1),
    .C0(C0),
    .tick(tick)
  );

  assign code = {C2, C1, C0};

  initial clk = 0;
  always #5 clk = ~clk;

  // Model: phase index, prescaler count, and ticks left in the phase.
  always @(posedge clk or negedge rst_n) begin : model
    if (!rst_n) begin
      m_ph   <= 0;
      m_pre  <= 0;
      m_left <= dw_ticks[0];
    end else if (en) begin : run
      automatic int ph = m_ph;
      automatic int left = m_left;
      automatic int pos = m_ph % 4;
      automatic bit dem = (m_ph >= 4) ? req1 : req2;
      if (m_pre == TD - 1) begin
        left = left - 1;
        if (pos == 1 && left == 0)
          ph = dem ? ph + 2 : ph + 1;
        else if (pos == 2 && (dem || left == 0))
          ph = ph + 1;
        else if (left == 0)
          ph = (ph + 1) % 8;
        if (ph != m_ph) left = dw_ticks[ph];
      end
      m_pre  <= (m_pre + 1) % TD;
      m_ph   <= ph;
      m_left <= left;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_code", int'(code), m_ph);
      check("model_tick", int'(tick),
            int'(en && rst_n && m_pre == TD - 1));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_code(input logic [2:0] c);
    int n = 0;
    while (code != c && n < 300) begin
      step();
      n++;
    end
    check("wait_code", int'(code), int'(c));
  endtask

  task automatic measure(input int pulse_at, input int which,
                         input int lo, input int hi,
                         output int len, output logic [2:0] nxt);
    logic [2:0] c = code;
    len = 0;
    do begin
      len++;
      if (len == pulse_at) begin
        if (which == 1) req1 = 1;
        else req2 = 1;
      end
      en = !(len >= lo && len <= hi);
      step();
      if (pulse_at > 0) begin
        req1 = 0;
        req2 = 0;
      end
    end while (code == c && len < 300);
    en = 1;
    nxt = code;
  endtask

  initial begin
    int len;
    logic [2:0] nxt;
    rst_n = 0;
    en = 1;
    req1 = 0;
    req2 = 0;
    repeat (3) step();
    chk_on = 1;
    check("reset_code", int'(code), 0);
    check("reset_tick", int'(tick), 0);
    rst_n = 1;
    for (int k = 1; k <= 9; k++) begin
      check($sformatf("tick_c%0d", k), int'(tick), int'(k == 4 || k == 8));
      if (k == 8) check("code_c8", int'(code), 0);
      if (k == 9) check("code_c9", int'(code), 1);
      if (k < 9) step();
    end

    for (int i = 1; i <= 8; i++) begin
      measure(0, 0, 0, -1, len, nxt);
      check($sformatf("free_len%0d", i % 8), len, durs[i % 8]);
      check($sformatf("free_nxt%0d", i % 8), int'(nxt), (i + 1) % 8);
    end

    req2 = 1;
    measure(0, 0, 0, -1, len, nxt);
    req2 = 0;
    check("skip_len", len, 12);
    check("skip_nxt", int'(nxt), 3);

    wait_code(3'd2);
    measure(8, 2, 0, -1, len, nxt);
    check("early2_len", len, 8);
    check("early2_nxt", int'(nxt), 3);
    wait_code(3'd2);
    measure(5, 2, 0, -1, len, nxt);
    check("off2_len", len, 16);
    wait_code(3'd6);
    measure(8, 1, 0, -1, len, nxt);
    check("early1_len", len, 8);
    check("early1_nxt", int'(nxt), 7);
    wait_code(3'd6);
    measure(5, 1, 0, -1, len, nxt);
    check("off1_len", len, 16);

    wait_code(3'd5);
    measure(0, 0, 5, 14, len, nxt);
    check("hold_len", len, 22);
    check("hold_nxt", int'(nxt), 6);

    wait_code(3'd7);
    step();
    rst_n = 0;
    #1;
    check("midrst_code", int'(code), 0);
    check("midrst_tick", int'(tick), 0);
    step();
    rst_n = 1;
    measure(0, 0, 0, -1, len, nxt);
    check("midrst_len", len, 8);
    check("midrst_nxt", int'(nxt), 1);

    for (int i = 0; i < 3000; i++) begin
      en = ($urandom % 8) != 0;
      req1 = ($urandom % 4) == 0;
      req2 = ($urandom % 4) == 0;
      if ($urandom % 400 == 0) begin
        #($urandom_range(1, 2));
        rst_n = 0;
        #1;
        check("rnd_rst_code", int'(code), 0);
        check("rnd_rst_tick", int'(tick), 0);
        step();
        rst_n = 1;
      end else begin
        step();
      end
    end

    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_phase_sequencer.md
# traffic_phase_sequencer

Timed phase sequencer for the two-road traffic light system. It produces the 3-bit phase code `C2 C1 C0` consumed directly by the light decoder. It steps through all-red, green, green-extension and yellow phases for road 1 and then road 2, with parameterised dwell times, a clock prescaler, and vehicle-demand inputs that shorten or skip the green extension.

## Interface
- `TICK_DIV`, default 100000000: clock cycles per timing tick (≥1).
- `T_RED`, default 2: all-red dwell, in ticks (≥1).
- `T_GREEN`, default 10: fixed green dwell, in ticks (≥1).
- `T_EXT`, default 10: maximum green-extension dwell, in ticks (≥1).
- `T_YELLOW`, default 3: yellow dwell, in ticks (≥1).
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `en`  in  1  run enable. Low freezes all state.
- `req1`  in  1  vehicle demand on road 1. Synchronous to `clk`.
- `req2`  in  1  vehicle demand on road 2. Synchronous to `clk`.
- `C2`, `C1`, `C0`  out  1 each  registered phase code (MSB..LSB).
- `tick`  out  1  combinational tick strobe, for debug and bench use.

## Operation
- **Phase codes and their order:**
  - 000 all-red (before road 1), then 001 G1, then 010 G1-extension, then 011 Y1.
  - 100 all-red (before road 2), then 101 G2, then 110 G2-extension, then 111 Y2.
  - 111 wraps to 000.
- **Dwell per phase:** 000/100 use `T_RED`; 001/101 use `T_GREEN`; 010/110 use `T_EXT`; 011/111 use `T_YELLOW`.
- **Prescaler `pre`:**
  - Counts 0..`TICK_DIV`-1 while `en`=1, then wraps.
  - `tick` = `en` & (`pre` == `TICK_DIV`-1).
  - With `TICK_DIV`=1, `tick` = `en`.
- **Dwell counter `cnt`:**
  - Loaded with (phase dwell − 1) on every phase entry.
  - On `tick` with `cnt`≠0, `cnt` decrements.
  - On `tick` with `cnt`==0, the phase ends.
  - Width is clog2 of the maximum T_* value, minimum 1 bit.
- **Demand rules.** Demand inputs are evaluated only in `tick` cycles; values outside tick cycles are ignored.
  - End of 001: if `req2`=1, go to 011 and skip 010; otherwise go to 010.
  - In 010: any `tick` with `req2`=1 ends the phase immediately, whatever `cnt` holds; the next phase is 011.
  - Road 2 mirrors this: 101 skips 110 if `req1`=1, and in 110 `req1`=1 ends the phase early.
  - Demand on the road that already has green is ignored.
  - `req` is never evaluated in all-red or yellow phases; those phases always run their full dwell.
- **`en` low:**
  - `pre`, `cnt` and the phase code hold their values.
  - `tick`=0.
  - Operation resumes exactly where it stopped.
- **Reset (asynchronous, while `rst_n`=0):**
  - Phase code = 000, `pre` = 0, `cnt` = `T_RED`-1.
  - `tick` = 0, because `en` is gated with the reset state.
  - Assertion in the middle of any phase aborts it immediately.
- **Illegal codes:** all 8 codes are legal, so there is no recovery state. The next state is a pure function of phase, `cnt` and the `req` inputs.

## Timing
- Phase code, `cnt` and `pre` update on the rising edge that ends a `tick` cycle. The new code is visible in the cycle after the `tick` cycle.
- Phase duration with `en` held high and no early exit = dwell × `TICK_DIV` cycles.
- First phase after reset release: `pre`=0 in the first cycle. The first `tick` is in cycle `TICK_DIV`, counting the first post-reset cycle as 1. The code leaves 000 after `T_RED`×`TICK_DIV` cycles.
- Early exit from an extension phase happens at the edge ending the `tick` cycle in which `req` is seen. Minimum extension length is 1 tick, i.e. `TICK_DIV` cycles.
- Skipped extension: the code goes 001→011 in a single step, with no intermediate 010 cycle.
- Each cycle with `en`=0 lengthens the current phase by exactly one cycle.
- There are no combinational paths from inputs to `C2..C0`. `tick` depends combinationally on `en`.

## Test plan
Bench parameters: `TICK_DIV`=4, `T_RED`=2, `T_GREEN`=3, `T_EXT`=4, `T_YELLOW`=1.

- **Reset.** Assert `rst_n`=0 at random points, with `en`=1 and `req`=0 → `C`=000 immediately and `tick`=0. After release, `tick` pulses in cycles 4 and 8, and `C`=001 from cycle 9.
- **Free run.** `en`=1, `req1`=`req2`=0 → the code sequence is 000,001,010,011,100,101,110,111 with durations 8,12,16,4,8,12,16,4 cycles. It then wraps to 000, for a period of 80 cycles.
- **Skip extension.** `req2`=1 held throughout 001 → 001 is followed directly by 011, with no 010 cycle. Total green time is 12 cycles.
- **Early exit.**
  - `req2` pulsed for one cycle aligned with the 2nd tick of 010 → code goes to 011 after 8 cycles of 010.
  - The same one-cycle pulse placed off the tick cycle → no effect; 010 lasts 16 cycles.
  - Repeat symmetrically with `req1` in 110.
- **Enable hold.** `en`=0 for 10 cycles in the middle of 101 → `C`, `pre` and `cnt` stay frozen and `tick`=0. Phase 101 lasts 22 cycles in total.
- **Reset mid-operation.** Assert `rst_n` low for one cycle during 111 → `C`=000 asynchronously. After release the full reset timing repeats: 8 cycles of 000, then 001.
